// File: rtl/sram_pkg.sv
// Shared types and constants for the MEM-stage external SRAM controller.
// The SRAM is 16 bits wide, so every 32-bit word occupies two consecutive half-word addresses.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SRAM_DW           = 16;
  localparam int SRAM_AW           = 18;
  localparam int WORD_AW           = SRAM_AW - 1;
  localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two timed 16-bit SRAM accesses.
// While an access is in flight, ready is held low so the pipeline stays frozen.
module sram_controller
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  localparam int PW = $clog2(WAIT_CYCLES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(WAIT_CYCLES - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [PW-1:0]        r_phase;
  logic                 r_isWrite;
  logic [WORD_AW-1:0]   r_wordIdx;
  logic [SRAM_DW-1:0]   r_wdataHi;
  logic [SRAM_DW-1:0]   r_shadowLo;
  logic [31:0]          r_readData;
  logic [SRAM_AW-1:0]   r_sramAddr;
  logic [SRAM_DW-1:0]   r_dqOut;

  logic                 w_accept;
  logic                 w_inPhase;
  logic                 w_phaseLast;
  logic [WORD_AW-1:0]   w_reqIdx;

  // Byte offset into the SRAM window, as a word index; address[1:0] falls away in the shift.
  assign w_reqIdx    = WORD_AW'((address - 32'(BASE_ADDR)) >> 2);
  assign w_inPhase   = (r_state == LO) || (r_state == HI);
  assign w_phaseLast = (r_phase == LAST_PHASE);

  assign read_data   = r_readData;
  assign sram_addr   = r_sramAddr;
  assign sram_dq_out = r_dqOut;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    ready       = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_en || wr_en) begin
          w_accept    = 1'b1;
          ready       = 1'b0;
          w_nextState = LO;
        end
      end
      LO: begin
        ready = 1'b0;
        if (w_phaseLast) w_nextState = HI;
      end
      HI: begin
        ready = 1'b0;
        if (w_phaseLast) w_nextState = DONE;
      end
      // The request still visible here belongs to the departing instruction.
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    // The last write cycle releases we_n so address and data are held across the strobe edge.
    if (w_inPhase && r_isWrite) begin
      sram_dq_oe = 1'b1;
      sram_we_n  = w_phaseLast;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_isWrite  <= 1'b0;
      r_wordIdx  <= '0;
      r_wdataHi  <= '0;
      r_shadowLo <= '0;
      r_readData <= '0;
      r_sramAddr <= '0;
      r_dqOut    <= '0;
    end else begin
      if (w_inPhase && !w_phaseLast) begin
        r_phase <= r_phase + PW'(1);
      end else begin
        r_phase <= '0;
      end

      if (w_accept) begin
        r_isWrite  <= wr_en;
        r_wordIdx  <= w_reqIdx;
        r_wdataHi  <= write_data[31:16];
        r_sramAddr <= {w_reqIdx, 1'b0};
        if (wr_en) r_dqOut <= write_data[15:0];
      end

      // Half boundary: move to the upper half-word, capturing the lower read half first.
      if ((r_state == LO) && w_phaseLast) begin
        r_sramAddr <= {r_wordIdx, 1'b1};
        if (r_isWrite) begin
          r_dqOut <= r_wdataHi;
        end else begin
          r_shadowLo <= sram_dq_in;
        end
      end

      if ((r_state == HI) && w_phaseLast && !r_isWrite) begin
        r_readData <= {sram_dq_in, r_shadowLo};
      end
    end
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage and the board's external 16-bit SRAM. It accepts one 32-bit word read or write per request, splits it into two 16-bit SRAM accesses, and sequences each access over a fixed number of wait cycles. While an access is in flight it holds `ready` low, and the top level uses that signal to freeze every pipeline register.

## Interface
- `WAIT_CYCLES`, 3: cycles each 16-bit half-access occupies; must be ≥ 2.
- `BASE_ADDR`, 1024: first byte address mapped to SRAM.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  MEM-stage read request.
- `wr_en`  in  1  MEM-stage write request.
- `address`  in  32  byte address from ALU result.
- `write_data`  in  32  store value.
- `read_data`  out  32  last completed read word.
- `ready`  out  1  high: MEM stage may advance; low: freeze pipeline.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_we_n`  out  1  SRAM write enable, active low.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  high: top-level tristate drives `sram_dq_out` onto the bus.
- `sram_dq_in`  in  16  data bus as read back from SRAM.
- SRAM `ce_n`, `oe_n`, `ub_n`, `lb_n` are tied low at top level. They are not ports.

## Operation
- Address map:
  - word index = (`address` − `BASE_ADDR`) >> 2, truncated to 17 bits.
  - `sram_addr` = {word index, half}. half 0 = low 16 bits, half 1 = high 16 bits.
  - `address[1:0]` is ignored. There is no range check.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - With `rd_en`|`wr_en` high: latch `address`, `write_data` and the operation, then go to LO.
  - Otherwise stay in IDLE.
  - If both `rd_en` and `wr_en` are high, the request is treated as a write.
- LO and HI:
  - Each state lasts exactly `WAIT_CYCLES` cycles, timed by a phase counter that resets on every state entry.
  - LO accesses half 0, HI accesses half 1.
  - LO → HI and HI → DONE happen on the last cycle of the phase.
- DONE: lasts one cycle, then always returns to IDLE.
  - The request still visible on this cycle belongs to the instruction now leaving MEM, so it is not re-accepted.
- `ready` is combinational:
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, so the freeze starts on the same cycle.
  - 0 in LO and HI.
  - 1 in DONE.
- Write phase:
  - `sram_dq_oe` = 1 and `sram_dq_out` = the latched half for the whole phase.
  - `sram_we_n` = 0 for every phase cycle except the last, which is 1 (address/data hold).
- Read phase:
  - `sram_dq_oe` = 0 and `sram_we_n` = 1.
  - On the last phase cycle, `sram_dq_in` is registered into the matching half of a shadow register.
  - `read_data` updates only on entry to DONE, with both halves at once, and holds until the next read completes.
  - Writes never change `read_data`.
- Outside LO/HI: `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` holds its last value.
- Request inputs that change after acceptance are ignored until the FSM is back in IDLE.

## Timing
- Reset values: state IDLE, `read_data` 0, `sram_addr` 0, `sram_we_n` 1, `sram_dq_oe` 0, `sram_dq_out` 0, phase counter 0. `ready` follows its IDLE rule.
- Request accepted at cycle T0:
  - LO covers T1..T`W`.
  - HI covers T`W`+1..T2`W`.
  - DONE is T2`W`+1.
  - `ready` is low for cycles T0..T2`W`, i.e. 2·`WAIT_CYCLES`+1 cycles.
- Back-to-back requests: the next request can be accepted at T2`W`+2, the IDLE cycle after DONE.
- Reset during any state: immediately IDLE with reset outputs. A write in progress is abandoned with `sram_we_n` forced to 1, and partial read data is discarded.
- Phase counter width is $clog2(`WAIT_CYCLES`). Terminal count is `WAIT_CYCLES`−1.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE, LO, HI, DONE)
  - SRAM data width 16 and address width 18
  - default `BASE_ADDR`
- No sub-module. The FSM, phase counter and data latches stay in one module.

## Test plan
- Reset then idle (no request) → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0.
- Write 0xDEADBEEF to address 1032 with W=3:
  - `sram_addr` is 4 then 5.
  - `sram_dq_out` is 0xBEEF then 0xDEAD.
  - `sram_we_n` is low 2 cycles per phase.
  - `ready` is low 7 cycles, high at T7.
- Read address 1032 with the SRAM model returning 0xBEEF/0xDEAD:
  - `read_data`=0xDEADBEEF from T7 onward.
  - `read_data` is unchanged during T1..T6.
- `rd_en` held high continuously across two instructions (1032 then 1036):
  - exactly two accesses occur, second accepted at T8.
  - no re-accept in DONE.
- `rst` asserted at T3 of a write → `sram_we_n`=1 and state IDLE asynchronously. A following read of the same word returns the SRAM model's contents with no partial update.
- `rd_en` and `wr_en` both high with `address`=1024 → write sequence on `sram_addr` 0/1. `read_data` is unchanged.
